// File: rtl/bus_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_if
// Purpose  : Simple single-beat request/ack memory bus (master and slave views).
// Revision : 1.0
// ============================================================================
interface bus_if;
  logic        bus_en;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic        ack;
  logic [31:0] rd_data;

  modport slave (
    input  bus_en, wr_en, wr_data, addr, byte_en,
    output ack, rd_data
  );

  modport master (
    output bus_en, wr_en, wr_data, addr, byte_en,
    input  ack, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/bus_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_slave
// Purpose  : Word-addressed RAM slave with programmable wait states and
//            out-of-range error reporting.
// Revision : 1.0
// ============================================================================
module bus_mem_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic  i_clk,
  input  logic  i_rst,
  bus_if.slave  bus_s,
  output logic  o_bus_err
);

  localparam int         c_IDX_W     = $clog2(MEM_WORDS);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_wait_cnt;
  logic [31:0]          r_addr;
  logic [31:0]          r_wr_data;
  logic                 r_wr_en;
  logic [3:0]           r_byte_en;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_ack;
  logic                 r_bus_err;
  logic [31:0]          r_rd_data;
  logic [31:0]          r_mem [MEM_WORDS];

  logic                 w_capture;
  logic                 w_go_resp;
  logic [31:0]          w_src_addr;
  logic                 w_src_wr;
  logic [31:0]          w_offset;
  logic                 w_in_range;
  logic [c_IDX_W-1:0]   w_rd_idx;
  logic                 w_mem_we;

  assign w_capture = (r_state == S_IDLE) && bus_s.bus_en;
  assign w_go_resp = (w_capture && (WAIT_CYCLES == 0)) ||
                     ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));

  // With no wait states the response is decided on the capture edge itself,
  // before the captured copies exist, so the live bus values are used there.
  assign w_src_addr = w_capture ? bus_s.addr  : r_addr;
  assign w_src_wr   = w_capture ? bus_s.wr_en : r_wr_en;
  assign w_offset   = w_src_addr - BASE_ADDR;
  assign w_in_range = (w_src_addr >= BASE_ADDR) && ((w_offset >> (c_IDX_W + 2)) == 32'd0);
  assign w_rd_idx   = w_offset[c_IDX_W+1:2];
  assign w_mem_we   = (r_state == S_RESP) && r_wr_en && !r_bus_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 32'd0;
      r_wr_data  <= 32'd0;
      r_wr_en    <= 1'b0;
      r_byte_en  <= 4'd0;
      r_idx      <= '0;
      r_ack      <= 1'b0;
      r_bus_err  <= 1'b0;
      r_rd_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus_s.bus_en) begin
            r_addr     <= bus_s.addr;
            r_wr_data  <= bus_s.wr_data;
            r_wr_en    <= bus_s.wr_en;
            r_byte_en  <= bus_s.byte_en;
            r_wait_cnt <= c_WAIT_LOAD;
            r_state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_ack     <= 1'b0;
          r_bus_err <= 1'b0;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Response outputs are registered on the edge entering RESP.
      if (w_go_resp) begin
        r_ack     <= 1'b1;
        r_bus_err <= !w_in_range;
        r_idx     <= w_rd_idx;
        if (!w_in_range) begin
          r_rd_data <= 32'd0;
        end else if (!w_src_wr) begin
          r_rd_data <= r_mem[w_rd_idx];
        end
      end
    end
  end

  // Memory contents survive reset; the write lands on the edge leaving RESP.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_byte_en[i]) begin
          r_mem[r_idx][8*i +: 8] <= r_wr_data[8*i +: 8];
        end
      end
    end
  end

  assign bus_s.ack     = r_ack;
  assign bus_s.rd_data = r_rd_data;
  assign o_bus_err     = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mem_slave
// Purpose  : Directed bench for bus_mem_slave, two wait-state configurations.
// Revision : 1.0
// ============================================================================
module tb_bus_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_a, err_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bus_if bus_a ();
  bus_if bus_b ();

  bus_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus_s(bus_a), .o_bus_err(err_a)
  );

  bus_mem_slave #(.MEM_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus_s(bus_b), .o_bus_err(err_b)
  );

  task automatic drive(input bit b, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    if (b) begin
      bus_b.bus_en = en; bus_b.wr_en = wr; bus_b.addr = a; bus_b.wr_data = d; bus_b.byte_en = be;
    end else begin
      bus_a.bus_en = en; bus_a.wr_en = wr; bus_a.addr = a; bus_a.wr_data = d; bus_a.byte_en = be;
    end
  endtask

  // One transaction; returns cycles from capture edge to the edge that sees ack.
  task automatic txn(input bit b, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit corrupt, output int cyc,
                     output logic [31:0] rd, output logic err, output logic linger);
    bit found;
    found = 1'b0;
    cyc   = 0;
    @(posedge clk); #1;
    drive(b, 1'b1, wr, a, d, be);
    @(posedge clk); #1;
    if (corrupt) drive(b, 1'b0, wr, a + 32'd4, 32'hFFFF_FFFF, 4'hF);
    else         drive(b, 1'b0, wr, a, d, be);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (b ? bus_b.ack : bus_a.ack) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL ack_timeout: addr %h got no ack, required ack within 20 cycles", a);
      cyc = -1;
    end
    rd  = b ? bus_b.rd_data : bus_a.rd_data;
    err = b ? err_b : err_a;
    @(negedge clk);
    linger = b ? (bus_b.ack | err_b) : (bus_a.ack | err_a);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus_a.ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack_a: got %b need 0", bus_a.ack); end
    n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rst_err_a: got %b need 0", err_a); end
    n_cmp++; if (bus_a.rd_data !== 32'd0) begin n_bad++; $display("FAIL rst_rd_a: got %h need 0", bus_a.rd_data); end
    n_cmp++; if (bus_b.ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack_b: got %b need 0", bus_b.ack); end
    n_cmp++; if (bus_b.rd_data !== 32'd0) begin n_bad++; $display("FAIL rst_rd_b: got %h need 0", bus_b.rd_data); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    int c; logic [31:0] rd; logic e, l;
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, c, rd, e, l);
    n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d need 3", c); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b need 0", e); end
    n_cmp++; if (l !== 1'b0) begin n_bad++; $display("FAIL wr_ack_width: got %b need 0", l); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d need 3", c); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h need deadbeef", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b need 0", e); end
  endtask

  task automatic test_byte_lanes();
    int c; logic [31:0] rd; logic e, l;
    txn(0, 1'b1, 32'h12, 32'h00AA_5500, 4'b0110, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_hold_on_write: got %h need deadbeef", rd); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'hDEAA_55EF) begin n_bad++; $display("FAIL byte_lanes: got %h need deaa55ef", rd); end
  endtask

  task automatic test_zero_be();
    int c; logic [31:0] rd; logic e, l;
    txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL zero_be_ack: got %0d need 3", c); end
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'hDEAA_55EF) begin n_bad++; $display("FAIL zero_be_mem: got %h need deaa55ef", rd); end
  endtask

  task automatic test_out_of_range();
    int c; logic [31:0] rd; logic e, l;
    txn(0, 1'b1, 32'h0, 32'hCAFE_0001, 4'hF, 0, c, rd, e, l);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b need 1", e); end
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oor_rd_data: got %h need 0", rd); end
    n_cmp++; if (l !== 1'b0) begin n_bad++; $display("FAIL oor_err_width: got %b need 0", l); end
    txn(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, c, rd, e, l);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b need 1", e); end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'hCAFE_0001) begin n_bad++; $display("FAIL oor_word0: got %h need cafe0001", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL word0_err: got %b need 0", e); end
    txn(0, 1'b1, 32'hFFC, 32'h1111_2222, 4'hF, 0, c, rd, e, l);
    txn(0, 1'b0, 32'hFFF, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'h1111_2222) begin n_bad++; $display("FAIL last_word: got %h need 11112222", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b need 0", e); end
  endtask

  task automatic test_wait_change();
    int c; logic [31:0] rd; logic e, l;
    txn(0, 1'b1, 32'h34, 32'h0102_0304, 4'hF, 0, c, rd, e, l);
    txn(0, 1'b1, 32'h30, 32'hA5A5_A5A5, 4'hF, 1, c, rd, e, l);
    txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL captured_wr: got %h need a5a5a5a5", rd); end
    txn(0, 1'b0, 32'h34, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'h0102_0304) begin n_bad++; $display("FAIL captured_addr: got %h need 01020304", rd); end
  endtask

  task automatic test_no_wait();
    int c; logic [31:0] rd; logic e, l;
    logic [3:0] pat;
    logic extra;
    txn(1, 1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, 0, c, rd, e, l);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL nowait_wr_latency: got %0d need 1", c); end
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL nowait_rd_latency: got %0d need 1", c); end
    n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL nowait_rd_data: got %h need 0badf00d", rd); end
    // bus_en held high: next capture only once the FSM is back in IDLE
    pat = 4'd0;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat = {pat[2:0], bus_b.ack};
    end
    drive(1, 1'b0, 1'b0, 32'h4, 32'h0, 4'h0);
    extra = 1'b0;
    repeat (3) begin
      @(negedge clk);
      extra = extra | bus_b.ack;
    end
    n_cmp++; if (pat !== 4'b1001) begin n_bad++; $display("FAIL held_en_pattern: got %b need 1001", pat); end
    n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL held_en_extra_ack: got %b need 0", extra); end
  endtask

  task automatic test_reset_abort();
    int c; logic [31:0] rd; logic e, l;
    logic seen;
    txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, c, rd, e, l);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, c, rd, e, l);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_a.rd_data !== 32'd0) begin n_bad++; $display("FAIL async_rst_rd: got %h need 0", bus_a.rd_data); end
    n_cmp++; if (bus_a.ack !== 1'b0) begin n_bad++; $display("FAIL async_rst_ack: got %b need 0", bus_a.ack); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus_a.ack;
    end
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus_a.ack;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL aborted_ack: got %b need 0", seen); end
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, c, rd, e, l);
    n_cmp++; if (rd !== 32'h1122_3344) begin n_bad++; $display("FAIL aborted_write: got %h need 11223344", rd); end
    n_cmp++; if (c !== 3) begin n_bad++; $display("FAIL post_rst_latency: got %0d need 3", c); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_zero_be();
    test_out_of_range();
    test_wait_change();
    test_no_wait();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
